// File: rtl/instr_ram_arb_pkg.sv
// Shared types and constants for the instruction BRAM port-B arbiter.
// Holds the sequencer state encoding and the requester identifiers.
package instr_ram_arb_pkg;

  localparam int LINE_WORDS_DEF = 8;
  localparam int OFFS_W         = $clog2(LINE_WORDS_DEF);

  typedef enum logic [2:0] {
    IDLE,
    DBG_ISSUE,
    DBG_RESP,
    FILL_ISSUE,
    FILL_DRAIN
  } state_t;

  typedef enum logic {
    DBG  = 1'b0,
    FILL = 1'b1
  } req_id_t;

endpackage

// File: rtl/instr_ram_b_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: on a tie, the requester not served last wins.
// The last-grant register only moves when a grant is actually taken.
module rr_arb2
  import instr_ram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_dbg,
  input  logic req_fill,
  input  logic update,
  output logic gnt_dbg,
  output logic gnt_fill
);

  req_id_t last_reg;

  always_comb begin
    gnt_dbg  = req_dbg  && (!req_fill || (last_reg == FILL));
    gnt_fill = req_fill && (!req_dbg  || (last_reg == DBG));
  end

  // Reset to FILL so debug wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg <= FILL;
    end else if (update && (gnt_dbg || gnt_fill)) begin
      last_reg <= gnt_dbg ? DBG : FILL;
    end
  end

endmodule

// File: rtl/instr_ram_b_arbiter.sv
// Port-B sequencer for the instruction BRAM: single-word debug accesses and
// uninterruptible line-refill bursts, arbitrated round-robin in IDLE.
module instr_ram_b_arbiter
  import instr_ram_arb_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dbg_req,
  input  logic                          dbg_we,
  input  logic [29:0]                   dbg_addr,
  input  logic [31:0]                   dbg_wdata,
  output logic                          dbg_gnt,
  output logic                          dbg_rvalid,
  output logic [31:0]                   dbg_rdata,
  input  logic                          fill_req,
  input  logic [29:0]                   fill_addr,
  output logic                          fill_ack,
  output logic                          fill_rvalid,
  output logic [31:0]                   fill_rdata,
  output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
  output logic                          fill_done,
  output logic                          ram_web,
  output logic [29:0]                   ram_addrb,
  output logic [31:0]                   ram_dinb,
  input  logic [31:0]                   ram_doutb
);

  localparam int CNT_W  = $clog2(LINE_WORDS);
  localparam int LINE_W = 30 - CNT_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [CNT_W-1:0]    fill_idx_reg;
  logic                fill_rvalid_reg;
  logic [29:0]         dbg_addr_reg;
  logic [31:0]         dbg_wdata_reg;
  logic                dbg_we_reg;
  logic [LINE_W-1:0]   line_reg;
  logic                gnt_dbg;
  logic                gnt_fill;
  logic                in_idle;
  logic                unused_fill_offs;

  // The line offset comes from cnt, so the requester's low bits are dropped.
  assign unused_fill_offs = ^fill_addr[CNT_W-1:0];
  assign in_idle          = (state_reg == IDLE);

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_dbg  (dbg_req),
    .req_fill (fill_req),
    .update   (in_idle),
    .gnt_dbg  (gnt_dbg),
    .gnt_fill (gnt_fill)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      fill_idx_reg    <= '0;
      fill_rvalid_reg <= 1'b0;
      dbg_addr_reg    <= '0;
      dbg_wdata_reg   <= '0;
      dbg_we_reg      <= 1'b0;
      line_reg        <= '0;
    end else begin
      // Read data trails the address by one cycle, so valid/idx do too.
      fill_rvalid_reg <= (state_reg == FILL_ISSUE);
      fill_idx_reg    <= cnt_reg;
      case (state_reg)
        IDLE: begin
          if (gnt_dbg) begin
            dbg_addr_reg  <= dbg_addr;
            dbg_wdata_reg <= dbg_wdata;
            dbg_we_reg    <= dbg_we;
            state_reg     <= DBG_ISSUE;
          end else if (gnt_fill) begin
            line_reg  <= fill_addr[29:CNT_W];
            cnt_reg   <= '0;
            state_reg <= FILL_ISSUE;
          end
        end
        DBG_ISSUE: state_reg <= DBG_RESP;
        DBG_RESP:  state_reg <= IDLE;
        FILL_ISSUE: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            state_reg <= FILL_DRAIN;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        FILL_DRAIN: state_reg <= IDLE;
        default:    state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    dbg_gnt     = 1'b0;
    dbg_rvalid  = 1'b0;
    dbg_rdata   = '0;
    fill_ack    = 1'b0;
    ram_web     = 1'b0;
    ram_addrb   = '0;
    ram_dinb    = '0;
    case (state_reg)
      DBG_ISSUE: begin
        dbg_gnt   = 1'b1;
        ram_addrb = dbg_addr_reg;
        ram_dinb  = dbg_wdata_reg;
        ram_web   = dbg_we_reg & ~rst;
      end
      DBG_RESP: begin
        dbg_rvalid = 1'b1;
        dbg_rdata  = ram_doutb;
      end
      FILL_ISSUE: begin
        fill_ack  = (cnt_reg == '0);
        ram_addrb = {line_reg, cnt_reg};
      end
      default: ;
    endcase
    fill_rvalid = fill_rvalid_reg;
    fill_rdata  = fill_rvalid_reg ? ram_doutb : '0;
    fill_idx    = fill_rvalid_reg ? fill_idx_reg : '0;
    fill_done   = (state_reg == FILL_DRAIN);
  end

endmodule

// File: tb/tb_instr_ram_b_arbiter.sv
// Directed bench for instr_ram_b_arbiter with a read-first BRAM model and
// scoreboard queues for debug and refill read data.
module tb_instr_ram_b_arbiter;

  localparam int LW = 8;
  localparam int OW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          dbg_req, dbg_we;
  logic [29:0]   dbg_addr;
  logic [31:0]   dbg_wdata;
  logic          dbg_gnt, dbg_rvalid;
  logic [31:0]   dbg_rdata;
  logic          fill_req;
  logic [29:0]   fill_addr;
  logic          fill_ack, fill_rvalid, fill_done;
  logic [31:0]   fill_rdata;
  logic [OW-1:0] fill_idx;
  logic          ram_web;
  logic [29:0]   ram_addrb;
  logic [31:0]   ram_dinb;
  logic [31:0]   ram_doutb;

  always #5 clk = ~clk;

  instr_ram_b_arbiter #(.LINE_WORDS(LW)) dut (
    .clk         (clk),
    .rst         (rst),
    .dbg_req     (dbg_req),
    .dbg_we      (dbg_we),
    .dbg_addr    (dbg_addr),
    .dbg_wdata   (dbg_wdata),
    .dbg_gnt     (dbg_gnt),
    .dbg_rvalid  (dbg_rvalid),
    .dbg_rdata   (dbg_rdata),
    .fill_req    (fill_req),
    .fill_addr   (fill_addr),
    .fill_ack    (fill_ack),
    .fill_rvalid (fill_rvalid),
    .fill_rdata  (fill_rdata),
    .fill_idx    (fill_idx),
    .fill_done   (fill_done),
    .ram_web     (ram_web),
    .ram_addrb   (ram_addrb),
    .ram_dinb    (ram_dinb),
    .ram_doutb   (ram_doutb)
  );

  // Read-first synchronous BRAM port B.
  logic [31:0] bram   [256];
  logic [31:0] shadow [256];
  always @(posedge clk) begin
    ram_doutb <= bram[ram_addrb[7:0]];
    if (ram_web) bram[ram_addrb[7:0]] <= ram_dinb;
  end

  typedef struct packed {
    logic [31:0]   data;
    logic [OW-1:0] idx;
    logic          done;
  } fill_exp_t;

  logic [31:0] dbg_q[$];
  fill_exp_t   fill_q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dbg_rvalid) begin
      if (dbg_q.size() == 0) begin
        checks++; errors++;
        $error("FAIL dbg_spurious_rvalid observed rdata=0x%08h expected no rvalid", dbg_rdata);
      end else begin
        logic [31:0] e;
        e = dbg_q.pop_front();
        chk("dbg_rdata", dbg_rdata, e);
        $display("dbg rsp rdata=0x%08h exp=0x%08h", dbg_rdata, e);
      end
    end
    if (fill_rvalid) begin
      if (fill_q.size() == 0) begin
        checks++; errors++;
        $error("FAIL fill_spurious_rvalid observed idx=%0d expected no rvalid", fill_idx);
      end else begin
        fill_exp_t f;
        f = fill_q.pop_front();
        chk("fill_rdata", fill_rdata, f.data);
        chk("fill_idx", fill_idx, f.idx);
        chk("fill_done", fill_done, f.done);
        $display("fill word idx=%0d data=0x%08h done=%0b", fill_idx, fill_rdata, fill_done);
      end
    end else if (fill_done) begin
      checks++; errors++;
      $error("FAIL fill_done_no_rvalid observed done=1 expected 0");
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {dbg_gnt, dbg_rvalid, fill_ack, fill_rvalid, fill_done, ram_web, fill_idx}, 0);
    chk({tag, "_addrb"}, ram_addrb, 0);
    chk({tag, "_dinb"}, ram_dinb, 0);
    chk({tag, "_dbg_rdata"}, dbg_rdata, 0);
    chk({tag, "_fill_rdata"}, fill_rdata, 0);
  endtask

  task automatic dbg_start(input logic we, input logic [29:0] a, input logic [31:0] d);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
  endtask

  task automatic dbg_wait_gnt(input int exp_wait, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!dbg_gnt && n < 50);
    chk({tag, "_gnt_lat"}, n, exp_wait);
  endtask

  task automatic dbg_finish(input logic we, input logic [29:0] a, input logic [31:0] d,
                            input int exp_wait, input string tag);
    dbg_wait_gnt(exp_wait, tag);
    chk({tag, "_addrb"}, ram_addrb, a);
    chk({tag, "_web"}, ram_web, we);
    chk({tag, "_dinb"}, ram_dinb, d);
    dbg_q.push_back(shadow[a[7:0]]);
    if (we) shadow[a[7:0]] = d;
    $display("dbg %s we=%0b addr=0x%0h wdata=0x%08h", tag, we, a, d);
    dbg_req = 1'b0;
    @(negedge clk);
    chk({tag, "_rvalid"}, dbg_rvalid, 1);
  endtask

  task automatic dbg_op(input logic we, input logic [29:0] a, input logic [31:0] d,
                        input int exp_wait, input string tag);
    dbg_start(we, a, d);
    dbg_finish(we, a, d, exp_wait, tag);
  endtask

  task automatic fill_wait_ack(input int exp_wait, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!fill_ack && n < 50);
    chk({tag, "_ack_lat"}, n, exp_wait);
    fill_req = 1'b0;
  endtask

  task automatic push_fill(input logic [29:0] fa, input int count);
    int b;
    fill_exp_t f;
    b = int'(fa[7:0]) & ~(LW - 1);
    for (int j = 0; j < count; j++) begin
      f.data = shadow[b + j];
      f.idx  = j[OW-1:0];
      f.done = (j == LW - 1);
      fill_q.push_back(f);
    end
  endtask

  // Called on the acknowledge cycle; returns on the drain cycle.
  task automatic fill_walk(input logic [29:0] fa, input string tag);
    logic [29:0] base;
    base = {fa[29:OW], {OW{1'b0}}};
    push_fill(fa, LW);
    $display("fill %s addr=0x%0h base=0x%0h", tag, fa, base);
    for (int i = 0; i < LW; i++) begin
      if (i > 0) @(negedge clk);
      chk({tag, "_addrb"}, ram_addrb, base + 30'(i));
      chk({tag, "_web"}, ram_web, 0);
      chk({tag, "_no_dbg_gnt"}, dbg_gnt, 0);
    end
    @(negedge clk);
    chk({tag, "_drain_done"}, fill_done, 1);
    chk({tag, "_drain_addrb"}, ram_addrb, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      bram[i]   = 32'hA500_0000 + i * 32'h0001_0003;
      shadow[i] = bram[i];
    end
    bram[0] = 32'h1000_4693; shadow[0] = 32'h1000_4693;
    bram[5] = 32'h0;         shadow[5] = 32'h0;
    rst = 1'b1; dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    fill_req = 1'b0; fill_addr = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    dbg_op(1'b0, 30'h0, 32'h0, 1, "rd0");
    @(negedge clk);
    chk_zero("idle_after_rd0");

    dbg_op(1'b1, 30'h5, 32'hDEAD_BEEF, 1, "wr5");
    dbg_op(1'b0, 30'h5, 32'h0, 2, "rd5");
    @(negedge clk);

    fill_req = 1'b1; fill_addr = 30'h13;
    fill_wait_ack(1, "fill13");
    fill_walk(30'h13, "fill13");
    @(negedge clk);
    chk_zero("fill13_idle");

    // Tie right after reset: debug first, then the held fill.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dbg_start(1'b0, 30'h21, 32'h0);
    fill_req = 1'b1; fill_addr = 30'h20;
    dbg_finish(1'b0, 30'h21, 32'h0, 1, "tie1_dbg");
    fill_wait_ack(2, "tie1_fill");
    fill_walk(30'h20, "tie1_fill");
    @(negedge clk);

    // Debug served last, so the next tie goes to fill.
    dbg_op(1'b0, 30'h22, 32'h0, 1, "solo_dbg");
    @(negedge clk);
    dbg_start(1'b0, 30'h23, 32'h0);
    fill_req = 1'b1; fill_addr = 30'h2F;
    fill_wait_ack(1, "tie2_fill");
    chk("tie2_no_dbg_gnt", dbg_gnt, 0);
    fill_walk(30'h2F, "tie2_fill");
    dbg_finish(1'b0, 30'h23, 32'h0, 2, "tie2_dbg");
    @(negedge clk);

    // Debug request raised mid-burst waits for the burst to finish.
    fill_req = 1'b1; fill_addr = 30'h35;
    fill_wait_ack(1, "burst_fill");
    dbg_start(1'b1, 30'h31, 32'hCAFE_F00D);
    fill_walk(30'h35, "burst_fill");
    dbg_finish(1'b1, 30'h31, 32'hCAFE_F00D, 2, "burst_dbg");
    @(negedge clk);

    // Reset during the fourth refill issue cycle.
    fill_req = 1'b1; fill_addr = 30'h40;
    fill_wait_ack(1, "rstfill");
    push_fill(30'h40, 3);
    repeat (3) @(negedge clk);
    chk("rstfill_addrb", ram_addrb, 30'h43);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rstfill");
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("rstfill_q_empty", fill_q.size(), 0);
    $display("fill rstfill aborted after idx 2");

    // Reset coinciding with a debug write must not write the BRAM.
    dbg_start(1'b1, 30'h7, 32'h1234_5678);
    dbg_wait_gnt(1, "rstwr");
    rst = 1'b1;
    dbg_req = 1'b0;
    @(negedge clk);
    chk_zero("rstwr");
    rst = 1'b0;
    @(negedge clk);
    $display("dbg rstwr write abandoned by reset");
    dbg_op(1'b0, 30'h7, 32'h0, 1, "rd7");

    repeat (3) @(negedge clk);
    chk("dbg_q_empty", dbg_q.size(), 0);
    chk("fill_q_empty", fill_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=no finish expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_ram_b_arbiter.md
# instr_ram_b_arbiter

Arbiter and sequencer for port B of the instruction BRAM, the synchronous, read-first, single-cycle-latency read/write port. Shares port B between two requesters: the debug module (single-word read/write) and the instruction-cache refill engine (line-burst reads). Grants alternate round-robin at transaction boundaries. A refill burst is never interrupted.

## Interface
- LINE_WORDS, 8, words per refill burst; power of two, 2..64
- clk  in  1  system clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- dbg_req  in  1  debug request; held until dbg_gnt
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  30  word address [31:2]
- dbg_wdata  in  32  write data
- dbg_gnt  out  1  one-cycle pulse: request accepted, inputs captured
- dbg_rvalid  out  1  one-cycle pulse: dbg_rdata valid
- dbg_rdata  out  32  read data (old contents on a write)
- fill_req  in  1  refill request; held until fill_ack
- fill_addr  in  30  word address; low log2(LINE_WORDS) bits ignored
- fill_ack  out  1  one-cycle pulse: burst accepted
- fill_rvalid  out  1  refill word valid
- fill_rdata  out  32  refill word
- fill_idx  out  log2(LINE_WORDS)  word offset of fill_rdata within the line
- fill_done  out  1  asserted with the last fill_rvalid
- ram_web  out  1  BRAM port-B write enable
- ram_addrb  out  30  BRAM port-B word address
- ram_dinb  out  32  BRAM port-B write data
- ram_doutb  in  32  BRAM port-B read data, valid the cycle after the address

## Operation
- States: IDLE, DBG_ISSUE, DBG_RESP, FILL_ISSUE, FILL_DRAIN.
- IDLE: samples dbg_req and fill_req.
  - Only one high: that requester wins.
  - Both high: the requester not served last wins. The last-served register resets to FILL, so debug wins the first tie.
  - Winner's inputs are captured at the same posedge.
- DBG_ISSUE (1 cycle):
  - dbg_gnt=1.
  - ram_addrb=captured address, ram_dinb=captured data, ram_web=captured we.
  - Next state: DBG_RESP.
- DBG_RESP (1 cycle):
  - dbg_rvalid=1, dbg_rdata=ram_doutb, passed through combinationally.
  - Next state: IDLE.
- FILL_ISSUE (LINE_WORDS cycles):
  - fill_ack=1 in the first cycle.
  - ram_addrb={line base, cnt}, with cnt counting 0..LINE_WORDS-1; ram_web=0.
  - After cnt=LINE_WORDS-1, next state is FILL_DRAIN. cnt never wraps into the next line.
- fill_rvalid is high from the second FILL_ISSUE cycle through FILL_DRAIN.
  - fill_rdata=ram_doutb; fill_idx=cnt delayed one cycle.
  - fill_done=1 only in FILL_DRAIN. FILL_DRAIN then returns to IDLE.
- A requester dropping req before it is granted is not served.
- A loser's held request is served at the next IDLE.
- Outside the issue states: ram_web=0, ram_addrb=0, ram_dinb=0.
- ram_web is gated with ~rst, so no write reaches the BRAM in a reset cycle.

## Timing
- Reset values: state IDLE, cnt 0, every output 0.
- Reset mid-transaction:
  - Return to IDLE; the transaction is abandoned.
  - No further rvalid, done, gnt or ack pulse is issued for it.
  - The requester must re-request.
- Debug: req sampled at edge t → dbg_gnt in cycle t+1 → dbg_rvalid in cycle t+2 → IDLE in t+3. Occupancy is 3 cycles.
- Refill: req sampled at edge t → fill_ack at t+1 → rvalid at t+2..t+LINE_WORDS+1 → IDLE at t+LINE_WORDS+2.
- Writes are read-first: dbg_rdata returns the pre-write word.
- Arbitration happens only in IDLE. Back-to-back transactions have one IDLE cycle between them.

## Structure
- Package instr_ram_arb_pkg holds:
  - the state enum
  - the LINE_WORDS default
  - OFFS_W = $clog2(LINE_WORDS)
  - the requester-id enum {DBG, FILL}
- Sub-module rr_arb2: 2-input round-robin arbiter with last-grant register, updated on the IDLE grant.
- FSM, capture registers, cnt and output muxing live in the top module.

## Test plan
- Debug read: BRAM word 0 = 0x10004693, dbg_req read addr 0 → gnt at t+1, rvalid at t+2, rdata=0x10004693, ram_web never 1.
- Debug write then read: write 0xDEADBEEF to addr 5 (old 0x00000000) → rvalid returns rdata 0x00000000; a following read of addr 5 returns 0xDEADBEEF.
- Refill with LINE_WORDS=8, fill_addr=0x13:
  - ram_addrb runs 0x10..0x17 on consecutive cycles.
  - fill_idx runs 0..7 with matching data.
  - fill_done only on idx 7.
  - IDLE at t+10.
- Simultaneous dbg_req and fill_req after reset → debug served first, then fill. Repeat both held → fill, then debug alternation.
- dbg_req raised during a burst → no grant until the burst ends; gnt in the cycle after the post-burst IDLE.
- rst=1 during the 4th FILL_ISSUE cycle → all outputs 0 next cycle, no fill_done, state IDLE. A debug write in DBG_ISSUE coinciding with rst=1 leaves the BRAM word unchanged.
